// File: rtl/iter_alu_pkg.sv
// Shared definitions for the iterative ALU: op codes, FSM state codes and flag bit positions.
package iter_alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_ORR   = 4'b0011;
  localparam logic [3:0] OP_EOR   = 4'b0100;
  localparam logic [3:0] OP_MOV   = 4'b0101;
  localparam logic [3:0] OP_MUL   = 4'b0110;
  localparam logic [3:0] OP_UMULH = 4'b0111;
  localparam logic [3:0] OP_UDIV  = 4'b1000;
  localparam logic [3:0] OP_UREM  = 4'b1001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ALUFlags is {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_UMULH) || (op == OP_UDIV) || (op == OP_UREM);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_UDIV) || (op == OP_UREM);
  endfunction

  function automatic logic [3:0] pack_flags(input logic n, input logic z, input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiply (radix-2 shift-add) and restoring divide, one bit per cycle.
module iter_muldiv import iter_alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic             active_q, active_d;
  logic             div_q, div_d;
  logic             hi_sel_q, hi_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] hi_step;
  logic [WIDTH-1:0] lo_step;

  // {hi,lo} is the product register for multiply and {remainder,dividend/quotient} for divide
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, m_q};
    // the partial remainder is below 2*divisor, so the low WIDTH bits of the difference are exact
    div_diff = div_sh[WIDTH-1:0] - m_q;
    if (div_q) begin
      hi_step = div_ge ? div_diff : div_sh[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    hi_sel_d = hi_sel_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (start) begin
      active_d = 1'b1;
      div_d    = is_div_op(op);
      hi_sel_d = (op == OP_UMULH) || (op == OP_UREM);
      cnt_d    = CNT_W'(WIDTH - 1);
      m_d      = is_div_op(op) ? src_b : src_a;
      hi_d     = '0;
      lo_d     = is_div_op(op) ? src_a : src_b;
    end else if (active_q) begin
      hi_d = hi_step;
      lo_d = lo_step;
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      active_q <= 1'b0;
      div_q    <= 1'b0;
      hi_sel_q <= 1'b0;
      cnt_q    <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      hi_sel_q <= hi_sel_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // done marks the final iteration; result is the value that iteration produces
  assign done   = active_q && (cnt_q == '0);
  assign result = hi_sel_q ? hi_step : lo_step;

endmodule

// File: rtl/iter_alu.sv
// ALU with single-cycle logic/arithmetic ops and iterative multiply/divide behind an IDLE/RUN/DONE FSM.
module iter_alu import iter_alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Src_A,
  input  logic [WIDTH-1:0] Src_B,
  input  logic [3:0]       ALUOp,
  input  logic             Carry,
  input  logic             Carry_used,
  input  logic             Reverse_B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  logic [WIDTH-1:0] b_rev;
  logic [WIDTH:0]   arith;
  logic [WIDTH-1:0] one_res;
  logic             one_c;
  logic             one_v;
  logic             div_zero;

  always_comb begin
    b_rev   = Reverse_B ? ~Src_B : Src_B;
    arith   = '0;
    one_res = '0;
    one_c   = 1'b0;
    one_v   = 1'b0;
    case (ALUOp)
      OP_ADD: begin
        arith   = {1'b0, Src_A} + {1'b0, b_rev} + {{WIDTH{1'b0}}, Carry & Carry_used};
        one_res = arith[WIDTH-1:0];
        one_c   = arith[WIDTH];
        one_v   = ~(Src_A[WIDTH-1] ^ b_rev[WIDTH-1]) & (Src_A[WIDTH-1] ^ arith[WIDTH-1]);
      end
      OP_SUB: begin
        // carry-in of 1 completes the two's complement unless a borrow is supplied
        arith   = {1'b0, Src_A} + {1'b0, ~Src_B} + {{WIDTH{1'b0}}, Carry_used ? Carry : 1'b1};
        one_res = arith[WIDTH-1:0];
        one_c   = arith[WIDTH];
        one_v   = (Src_A[WIDTH-1] ^ Src_B[WIDTH-1]) & (Src_A[WIDTH-1] ^ arith[WIDTH-1]);
      end
      OP_AND:  one_res = Src_A & b_rev;
      OP_ORR:  one_res = Src_A | Src_B;
      OP_EOR:  one_res = Src_A ^ Src_B;
      OP_MOV:  one_res = b_rev;
      OP_UDIV: one_res = '1;
      OP_UREM: one_res = Src_A;
      default: one_res = '0;
    endcase
  end

  assign div_zero = is_div_op(ALUOp) && (Src_B == '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    md_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (is_iter_op(ALUOp) && !div_zero) begin
            md_start = 1'b1;
            state_d  = ST_RUN;
          end else begin
            state_d  = ST_DONE;
            result_d = one_res;
            flags_d  = pack_flags(one_res[WIDTH-1], one_res == '0, one_c, one_v);
          end
        end
      end
      ST_RUN: begin
        if (md_done) begin
          state_d  = ST_DONE;
          result_d = md_result;
          flags_d  = pack_flags(md_result[WIDTH-1], md_result == '0, 1'b0, 1'b0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  iter_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk    (CLK),
    .srst   (Reset),
    .start  (md_start),
    .op     (ALUOp),
    .src_a  (Src_A),
    .src_b  (Src_B),
    .done   (md_done),
    .result (md_result)
  );

  assign Busy     = (state_q == ST_RUN);
  assign Done     = (state_q == ST_DONE);
  assign Result   = result_q;
  assign ALUFlags = flags_q;

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter WIDTH, default 32: datapath width; legal values are even and at least 8.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1: width of the iteration counter.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request pulse; sampled only in IDLE.
REQ-006 Src_A  input  WIDTH  operand A; multiplicand or dividend.
REQ-007 Src_B  input  WIDTH  operand B; multiplier or divisor.
REQ-008 ALUOp  input  4  operation select (REQ-013).
REQ-009 Carry, Carry_used, Reverse_B  input  1 each  carry-in, carry-enable and B-invert controls for the 1-cycle ops.
REQ-010 Busy  output  1  high while a multi-cycle op iterates.
REQ-011 Done  output  1  one-cycle pulse; Result and ALUFlags valid.
REQ-012 Result  output  WIDTH  registered result; ALUFlags  output  4  registered {N,Z,C,V}.

Function
REQ-013 ALUOp encoding: 0000 ADD, 0001 SUB, 0010 AND/BIC, 0011 ORR, 0100 EOR, 0101 MOV/MVN, 0110 MUL (low WIDTH bits), 0111 UMULH (high WIDTH bits, unsigned), 1000 UDIV, 1001 UREM; 1010-1111 give Result 0.
REQ-014 The FSM has states IDLE, RUN and DONE.
REQ-015 IDLE with Start=1 latches the operands and ALUOp; all other inputs are ignored outside IDLE.
REQ-016 For op codes 0000-0101 and 1010-1111, IDLE goes to DONE; Done=1 the cycle after Start (latency 1).
REQ-017 For op codes 0110-1001 with a nonzero divisor where relevant, IDLE goes to RUN; RUN runs for exactly WIDTH cycles, then DONE; Done=1 at Start+WIDTH+1.
REQ-018 DONE lasts one cycle and then returns to IDLE.
REQ-019 A Start in the DONE cycle is ignored; back-to-back issue therefore has a 2-cycle minimum spacing for 1-cycle ops.
REQ-020 Busy = (state==RUN).
REQ-021 Result and ALUFlags hold their value from Done until the next Done.
REQ-022 ADD: A+B'+(Carry&Carry_used).
REQ-023 SUB: A+~B+1-((~Carry)&Carry_used).
REQ-024 AND uses B or ~B per Reverse_B; MOV returns B or ~B per Reverse_B.
REQ-025 ORR and EOR use B uninverted.
REQ-026 Arithmetic is WIDTH+1 bits wide; C is the carry out of bit WIDTH-1.
REQ-027 V = ~(A[msb]^B[msb]^sub) & (A[msb]^R[msb]), for ADD and SUB only.
REQ-028 For logic, MUL/UMULH and DIV/REM ops, C=0 and V=0; N=Result[WIDTH-1] and Z=(Result==0) for every op.
REQ-029 Multiply is radix-2 shift-add over a 2*WIDTH-bit product register, one multiplier bit per RUN cycle.
REQ-030 Divide is restoring, one quotient bit per RUN cycle.
REQ-031 Divisor 0 skips RUN and goes to DONE: UDIV gives all-ones, UREM gives Src_A; flags follow REQ-028.
REQ-032 The counter counts WIDTH-1 down to 0; leaving RUN when it reaches 0 and no wrap is allowed.

Reset
REQ-033 Reset=1 at any clock edge forces IDLE, Busy=0, Done=0, Result=0, ALUFlags=0, counter=0, and clears the working registers.
REQ-034 Reset during RUN aborts the operation with no Done pulse.
REQ-035 Reset dominates a simultaneous Start.
REQ-036 The first Start is accepted in the cycle after Reset falls.

Structure
REQ-037 The ALUOp codes, the FSM state encodings and the flag bit positions live in a shared package (iter_alu_pkg) used by the decoder and testbench.
REQ-038 The iterative multiply/divide datapath is one sub-module, iter_muldiv, with its own start/done; iter_alu owns the FSM, 1-cycle ops and flag registers.

Verification
REQ-039 WIDTH=32, ADD 0x7FFFFFFF+1, Carry_used=0 -> Done at +1, Result 0x80000000, flags N=1 Z=0 C=0 V=1.
REQ-040 SUB 5-5, Carry=1, Carry_used=1 -> Result 0, flags Z=1 C=1 V=0.
REQ-041 UMULH 0xFFFFFFFF*0xFFFFFFFF -> Busy for 32 cycles, Done at Start+33, Result 0xFFFFFFFE; MUL with the same operands -> 0x00000001.
REQ-042 UDIV 100/7 -> 14 and UREM -> 2 at Start+33; UDIV x/0 -> 0xFFFFFFFF at Start+1 with N=1.
REQ-043 Reset asserted at RUN cycle 10 -> no Done, all outputs 0; a new ADD issued next cycle completes normally.
REQ-044 Repeat REQ-041 and REQ-042 with WIDTH=8 (0xFF*0xFF high byte 0xFE, Done at Start+9); a Start during Busy is ignored.
